axi4_slave_mem: RTL

- Synthesizable AXI4 slave: a word-addressed memory that answers a master DUT, i.e. the responder end of the AXI4 link.
- Sits in benches and FPGA test images wherever a master under test needs a real memory target.
- Independent write (AW/W/B) and read (AR/R) engines, one outstanding transaction each.
- Also raises a doorbell interrupt (optional).

---
 rtl/axi4_slave_mem.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/axi4_slave_mem.sv
// axi4_slave_mem: word-addressed AXI4 memory slave, one outstanding write and one read.
// Define AXI4_SLAVE_MEM_IRQ_EN to add the doorbell interrupt on the last memory word.
module axi4_slave_mem #(
    parameter int data_width = 32,
    parameter int addr_width = 32,
    parameter int wid_width = 4,
    parameter int rid_width = 4,
    parameter int irq_width = 1,
    parameter int mem_words = 1024,
    parameter logic [addr_width-1:0] base_addr = '0,
    parameter int strb_width = data_width / 8
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [addr_width-1:0] AWADDR,
    input  logic [7:0]            AWLEN,
    input  logic [2:0]            AWSIZE,
    input  logic [1:0]            AWBURST,
    input  logic [wid_width-1:0]  AWID,
    input  logic                  WVALID,
    output logic                  WREADY,
    input  logic [data_width-1:0] WDATA,
    input  logic [strb_width-1:0] WSTRB,
    input  logic                  WLAST,
    output logic                  BVALID,
    input  logic                  BREADY,
    output logic [1:0]            BRESP,
    output logic [wid_width-1:0]  BID,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    input  logic [addr_width-1:0] ARADDR,
    input  logic [7:0]            ARLEN,
    input  logic [2:0]            ARSIZE,
    input  logic [1:0]            ARBURST,
    input  logic [rid_width-1:0]  ARID,
    output logic                  RVALID,
    input  logic                  RREADY,
    output logic [data_width-1:0] RDATA,
    output logic [1:0]            RRESP,
    output logic [rid_width-1:0]  RID,
    output logic                  RLAST,
    output logic [irq_width-1:0]  IRQ
);

    localparam int size_code = $clog2(strb_width);
    localparam int idx_width = $clog2(mem_words);
    localparam int ext_width = addr_width + size_code + 10;
    localparam logic [ext_width-1:0] span = ext_width'(mem_words * strb_width);
    localparam logic [ext_width-1:0] base = ext_width'(base_addr);
    localparam logic [1:0] resp_okay = 2'b00;
    localparam logic [1:0] resp_slverr = 2'b10;
    localparam logic [1:0] resp_decerr = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

    // Offsets below base wrap to huge values in the wide domain, so one compare covers both ends.
    function automatic logic [1:0] check_req(
        input logic [addr_width-1:0] addr,
        input logic [7:0]            len,
        input logic [2:0]            size,
        input logic [1:0]            burst
    );
        logic [ext_width-1:0] first;
        logic [ext_width-1:0] last;
        first = ext_width'(addr) - base;
        last = (burst == 2'b00) ? first
             : first + ext_width'(len) * ext_width'(strb_width);
        if (first >= span || last >= span)
            check_req = resp_decerr;
        else if (size != 3'(size_code) || burst[1])
            check_req = resp_slverr;
        else
            check_req = resp_okay;
    endfunction

    logic [data_width-1:0] mem [mem_words];
    logic alive;

    w_state_t w_state, w_next;
    logic [idx_width-1:0] w_idx;
    logic [7:0] w_len, w_cnt;
    logic w_fixed, w_bad, w_final;
    logic [1:0] w_err, b_resp;
    logic [wid_width-1:0] w_id;
    logic aw_hs, w_hs, b_hs;

    r_state_t r_state, r_next;
    logic [idx_width-1:0] r_idx;
    logic [7:0] r_len, r_cnt;
    logic r_fixed, r_final;
    logic [1:0] r_err;
    logic [rid_width-1:0] r_id;
    logic [data_width-1:0] r_data;
    logic ar_hs, r_hs;

    // Holds the READY outputs low while reset is asserted.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) alive <= 1'b0;
        else        alive <= 1'b1;
    end

    assign AWREADY = alive && (w_state == W_IDLE);
    assign WREADY  = (w_state == W_DATA);
    assign BVALID  = (w_state == W_RESP);
    assign BRESP   = b_resp;
    assign BID     = w_id;
    assign aw_hs   = AWVALID && AWREADY;
    assign w_hs    = WVALID && WREADY;
    assign b_hs    = BVALID && BREADY;
    assign w_final = (w_cnt == w_len);

    always_comb begin
        w_next = w_state;
        unique case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs && w_final) w_next = W_RESP;
            W_RESP:  if (b_hs) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_state <= W_IDLE;
            w_idx   <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_fixed <= 1'b0;
            w_bad   <= 1'b0;
            w_err   <= resp_okay;
            b_resp  <= resp_okay;
            w_id    <= '0;
        end else begin
            w_state <= w_next;
            if (aw_hs) begin
                w_idx   <= AWADDR[size_code +: idx_width];
                w_len   <= AWLEN;
                w_cnt   <= '0;
                w_fixed <= (AWBURST == 2'b00);
                w_bad   <= 1'b0;
                w_err   <= check_req(AWADDR, AWLEN, AWSIZE, AWBURST);
                w_id    <= AWID;
            end
            if (w_hs) begin
                w_cnt <= w_cnt + 8'd1;
                if (!w_fixed) w_idx <= w_idx + idx_width'(1);
                if (WLAST != w_final) w_bad <= 1'b1;
                if (w_final)
                    b_resp <= (w_err != resp_okay) ? w_err
                            : (w_bad || !WLAST) ? resp_slverr : resp_okay;
            end
        end
    end

    // Contents survive reset on purpose.
    always_ff @(posedge ACLK) begin
        if (w_hs && w_err == resp_okay)
            for (int b = 0; b < strb_width; b++)
                if (WSTRB[b]) mem[w_idx][b*8 +: 8] <= WDATA[b*8 +: 8];
    end

    assign ARREADY = alive && (r_state == R_IDLE);
    assign RVALID  = (r_state == R_DATA);
    assign RDATA   = r_data;
    assign RRESP   = r_err;
    assign RID     = r_id;
    assign r_final = (r_cnt == r_len);
    assign RLAST   = RVALID && r_final;
    assign ar_hs   = ARVALID && ARREADY;
    assign r_hs    = RVALID && RREADY;

    always_comb begin
        r_next = r_state;
        unique case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_FETCH;
            R_FETCH: r_next = R_DATA;
            R_DATA:  if (r_hs) r_next = r_final ? R_IDLE : R_FETCH;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state <= R_IDLE;
            r_idx   <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_fixed <= 1'b0;
            r_err   <= resp_okay;
            r_id    <= '0;
            r_data  <= '0;
        end else begin
            r_state <= r_next;
            if (ar_hs) begin
                r_idx   <= ARADDR[size_code +: idx_width];
                r_len   <= ARLEN;
                r_cnt   <= '0;
                r_fixed <= (ARBURST == 2'b00);
                r_err   <= check_req(ARADDR, ARLEN, ARSIZE, ARBURST);
                r_id    <= ARID;
            end
            if (r_state == R_FETCH)
                r_data <= (r_err != resp_okay) ? '0 : mem[r_idx];
            if (r_hs) begin
                r_cnt <= r_cnt + 8'd1;
                if (!r_fixed) r_idx <= r_idx + idx_width'(1);
            end
        end
    end

`ifdef AXI4_SLAVE_MEM_IRQ_EN
    localparam logic [idx_width-1:0] last_idx = idx_width'(mem_words - 1);
    logic irq_q;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET)
            irq_q <= 1'b0;
        else if (w_hs && w_err == resp_okay && w_idx == last_idx && WSTRB[0])
            irq_q <= 1'b1;
        else if (r_hs && r_idx == last_idx)
            irq_q <= 1'b0;
    end

    assign IRQ = irq_width'(irq_q);
`else
    assign IRQ = '0;
`endif

endmodule
